dm_port_arbiter: RTL and testbench
==================================

Name: dm_port_arbiter

Overview:
- Shares the single data-memory port between two requesters.
- Port 0 is the CPU M-stage load/store port; port 1 is a secondary master (DMA or debug loader).
- Memory side matches the existing DM contract: word-indexed combinational read, byte-enabled write at posedge clk, write only when byteen != 0.
- Per-cycle round-robin arbitration with an optional bounded burst lock; the CPU uses ~m0_ack as its memory stall.

Parameters:
- LOCK_MAX, 4: maximum consecutive grants a locking master may hold (range 1..15).
- ADDR_W, 32: byte-address width.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- m0_req  in  1  port 0 access request
- m0_addr  in  ADDR_W  port 0 byte address
- m0_wdata  in  32  port 0 write data
- m0_byteen  in  4  port 0 byte enables; 0 = read
- m0_lock  in  1  port 0 requests to keep the grant next cycle
- m0_ack  out  1  port 0 granted this cycle; read data valid / write commits at next posedge
- m0_rdata  out  32  port 0 read data
- m1_req, m1_addr, m1_wdata, m1_byteen, m1_lock, m1_ack, m1_rdata: same as port 0, for port 1
- mem_addr  out  ADDR_W  to DM, byte address
- mem_wdata  out  32  to DM
- mem_byteen  out  4  to DM; nonzero = write
- mem_rdata  in  32  from DM, combinational
- owner  out  1  port currently granted (valid when any ack is high)

Behaviour:
- State registers:
  - prio: port that wins a tie; reset 0.
  - lk_valid, lk_id: lock active flag and locked port; reset 0, 0.
  - lk_cnt: 4-bit count of consecutive locked grants; reset 0.
- Grant is combinational from the requests and registered state:
  - If lk_valid and m{lk_id}_req: grant lk_id.
  - Otherwise, if exactly one port requests: grant that port.
  - Otherwise, if both request: grant prio.
  - Otherwise: no grant.
- Zero-latency acknowledge: m{g}_ack = 1 in the same cycle as the grant; at most one ack is high.
- Datapath muxing:
  - mem_addr and mem_wdata follow the granted port; both are 0 when there is no grant.
  - mem_byteen = granted port's byteen; forced to 4'b0 when there is no grant or reset = 1. No spurious writes, ever.
  - m0_rdata = m1_rdata = mem_rdata, broadcast; meaningful only while the corresponding ack is high.
- Posedge update when a grant g occurs:
  - prio <= ~g (loser of this cycle gets priority next).
  - If m{g}_lock and the grant lands in the current lock run (or a new run starts at lk_cnt 0), and lk_cnt + 1 < LOCK_MAX: lk_valid <= 1, lk_id <= g, lk_cnt <= lk_cnt + 1.
  - Otherwise: lk_valid <= 0, lk_cnt <= 0.
- Posedge update with no grant: prio unchanged; lk_valid <= 0, lk_cnt <= 0.
- Locked owner drops req: the lock releases immediately that cycle; the other port may be granted combinationally.
- Lock cap: after LOCK_MAX consecutive locked grants the lock is released, and prio points at the other port, so a waiting port is guaranteed a grant within LOCK_MAX+1 cycles.
- LOCK_MAX = 1 disables locking (plain alternation).
- Reset:
  - Asynchronous assertion clears all state immediately.
  - Both acks are 0 and mem_byteen is 0 throughout reset, including when reset is asserted mid-burst.
  - The first cycle after deassertion favours port 0.
- Write and read to the same word by different ports in consecutive cycles: the second access sees the new data. No internal buffering, no hazard logic.
- Address is passed unchanged. Alignment masking and range checks belong to DM.

Decomposition:
- Shared package (dm_bus_pkg):
  - BYTEEN_W = 4.
  - PORT_CPU = 0, PORT_AUX = 1.
  - Byteen constants: BE_WORD = 4'hf, BE_NONE = 4'h0.
- One sub-module: dm_arb_lock_state, containing the prio/lk_valid/lk_id/lk_cnt registers and the next-state logic.
- The top level is the grant decode and the datapath muxes.

Test Plan:
- m0 only: m0_req=1, addr=0x10, byteen=f, wdata=0xdeadbeef → m0_ack=1 same cycle, mem_byteen=f, mem_addr=0x10; next cycle a read from 0x10 on m1 returns 0xdeadbeef.
- Both request, no lock, held 4 cycles from reset → acks alternate m0,m1,m0,m1; owner toggles 0,1,0,1.
- LOCK_MAX=4, m1 req+lock continuously, m0 req continuously → m1 granted 4 cycles, then m0 for 1 cycle, then m1 for 4 cycles; m0 never waits more than 4 cycles.
- m1 locked, drops req mid-burst while m0 requests → m0_ack=1 in the same cycle; lk_valid clears.
- Reset asserted asynchronously mid-cycle during an m1 write burst → mem_byteen=0 and both acks=0 immediately; no DM word changes; after release, simultaneous requests grant m0 first.
- No requests for 10 cycles → mem_byteen=0, acks=0, mem_addr=0 every cycle.

Source files
------------

// File: rtl/dm_bus_pkg.sv
// Shared constants for the data-memory port bus: byte-enable width, port ids
// and the common byte-enable patterns.
package dm_bus_pkg;

  localparam int unsigned BYTEEN_W = 4;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_AUX = 1'b1;

  localparam logic [BYTEEN_W-1:0] BE_WORD = 4'hf;
  localparam logic [BYTEEN_W-1:0] BE_NONE = 4'h0;

endpackage

// File: rtl/dm_arb_lock_state.sv
// Arbitration state for the DM port arbiter: tie-break priority plus the
// bounded burst-lock run (owner, active flag, consecutive grant count).
module dm_arb_lock_state
  import dm_bus_pkg::*;
#(
  parameter int unsigned LOCK_MAX = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic gnt_valid,
  input  logic gnt_id,
  input  logic gnt_lock,
  output logic prio,
  output logic lk_valid,
  output logic lk_id
);

  localparam int unsigned CNT_W = 4;
  localparam logic [CNT_W:0] LOCK_LIM = (CNT_W + 1)'(LOCK_MAX);

  logic             prio_q, prio_d;
  logic             lk_valid_q, lk_valid_d;
  logic             lk_id_q, lk_id_d;
  logic [CNT_W-1:0] lk_cnt_q, lk_cnt_d;
  logic [CNT_W-1:0] run_base;

  // A grant continues the run only if it goes to the current lock owner;
  // any other grant starts counting from zero.
  always_comb begin
    prio_d     = prio_q;
    lk_valid_d = 1'b0;
    lk_id_d    = lk_id_q;
    lk_cnt_d   = '0;
    run_base   = '0;
    if (gnt_valid) begin
      prio_d   = ~gnt_id;
      run_base = (lk_valid_q && (lk_id_q == gnt_id)) ? lk_cnt_q : '0;
      if (gnt_lock && (({1'b0, run_base} + (CNT_W + 1)'(1)) < LOCK_LIM)) begin
        lk_valid_d = 1'b1;
        lk_id_d    = gnt_id;
        lk_cnt_d   = run_base + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prio_q     <= PORT_CPU;
      lk_valid_q <= 1'b0;
      lk_id_q    <= PORT_CPU;
      lk_cnt_q   <= '0;
    end else begin
      prio_q     <= prio_d;
      lk_valid_q <= lk_valid_d;
      lk_id_q    <= lk_id_d;
      lk_cnt_q   <= lk_cnt_d;
    end
  end

  assign prio     = prio_q;
  assign lk_valid = lk_valid_q;
  assign lk_id    = lk_id_q;

endmodule

// File: rtl/dm_port_arbiter.sv
// Two-master arbiter for the single data-memory port: combinational grant and
// zero-latency ack, round-robin with bounded burst lock, datapath muxing.
module dm_port_arbiter
  import dm_bus_pkg::*;
#(
  parameter int unsigned LOCK_MAX = 4,
  parameter int unsigned ADDR_W   = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                m0_req,
  input  logic [ADDR_W-1:0]   m0_addr,
  input  logic [31:0]         m0_wdata,
  input  logic [BYTEEN_W-1:0] m0_byteen,
  input  logic                m0_lock,
  output logic                m0_ack,
  output logic [31:0]         m0_rdata,
  input  logic                m1_req,
  input  logic [ADDR_W-1:0]   m1_addr,
  input  logic [31:0]         m1_wdata,
  input  logic [BYTEEN_W-1:0] m1_byteen,
  input  logic                m1_lock,
  output logic                m1_ack,
  output logic [31:0]         m1_rdata,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [31:0]         mem_wdata,
  output logic [BYTEEN_W-1:0] mem_byteen,
  input  logic [31:0]         mem_rdata,
  output logic                owner
);

  logic       prio, lk_valid, lk_id;
  logic       gnt_valid, gnt_id, gnt_lock;
  logic [1:0] req;

  assign req = {m1_req, m0_req};

  // Nothing is granted while reset is high, so no ack and no write can leak out.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_id    = PORT_CPU;
    if (!reset) begin
      if (lk_valid && req[lk_id]) begin
        gnt_valid = 1'b1;
        gnt_id    = lk_id;
      end else if (req == 2'b11) begin
        gnt_valid = 1'b1;
        gnt_id    = prio;
      end else if (req != 2'b00) begin
        gnt_valid = 1'b1;
        gnt_id    = m1_req ? PORT_AUX : PORT_CPU;
      end
    end
  end

  always_comb begin
    mem_addr   = '0;
    mem_wdata  = '0;
    mem_byteen = BE_NONE;
    gnt_lock   = 1'b0;
    if (gnt_valid) begin
      mem_addr   = (gnt_id == PORT_AUX) ? m1_addr   : m0_addr;
      mem_wdata  = (gnt_id == PORT_AUX) ? m1_wdata  : m0_wdata;
      mem_byteen = (gnt_id == PORT_AUX) ? m1_byteen : m0_byteen;
      gnt_lock   = (gnt_id == PORT_AUX) ? m1_lock   : m0_lock;
    end
  end

  assign m0_ack   = gnt_valid && (gnt_id == PORT_CPU);
  assign m1_ack   = gnt_valid && (gnt_id == PORT_AUX);
  assign owner    = gnt_id;
  assign m0_rdata = mem_rdata;
  assign m1_rdata = mem_rdata;

  dm_arb_lock_state #(
    .LOCK_MAX (LOCK_MAX)
  ) u_lock_state (
    .clk      (clk),
    .reset    (reset),
    .gnt_valid(gnt_valid),
    .gnt_id   (gnt_id),
    .gnt_lock (gnt_lock),
    .prio     (prio),
    .lk_valid (lk_valid),
    .lk_id    (lk_id)
  );

endmodule

// File: tb/tb_dm_port_arbiter.sv
// Bench for dm_port_arbiter: a small DM attached to the memory side, a
// behavioural arbiter/memory model checked every cycle, plus directed scenarios.
module tb_dm_port_arbiter;

  localparam int unsigned LOCK_MAX = 4;
  localparam int unsigned ADDR_W   = 32;

  logic        clk, reset;
  logic        m0_req, m0_lock, m0_ack, m1_req, m1_lock, m1_ack, owner;
  logic [31:0] m0_addr, m0_wdata, m0_rdata, m1_addr, m1_wdata, m1_rdata;
  logic [3:0]  m0_byteen, m1_byteen, mem_byteen;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  dm_port_arbiter #(.LOCK_MAX(LOCK_MAX), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_byteen(m0_byteen),
    .m0_lock(m0_lock), .m0_ack(m0_ack), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_byteen(m1_byteen),
    .m1_lock(m1_lock), .m1_ack(m1_ack), .m1_rdata(m1_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_byteen(mem_byteen),
    .mem_rdata(mem_rdata), .owner(owner)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    else n_pass++;
  endtask

  // DM attached to the arbiter: combinational word read, byte-enabled write.
  logic [31:0] dm_mem [16] = '{default: 32'h0};
  assign mem_rdata = dm_mem[mem_addr[5:2]];
  always @(posedge clk) begin
    for (int b = 0; b < 4; b++)
      if (mem_byteen[b]) dm_mem[mem_addr[5:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
  end

  // Reference model: who wins, the lock run, and the expected memory image.
  logic [31:0] exp_mem [16] = '{default: 32'h0};
  int          m_prio = 0, run_port = -1, run_len = 0;
  int          st_g = -1;
  logic        st_lock;
  logic [3:0]  st_be;
  logic [31:0] st_addr, st_wdata;

  always @(negedge clk) begin
    int          g;
    logic [1:0]  rq;
    logic [31:0] ea, ew;
    logic [3:0]  eb;
    rq = {m1_req, m0_req};
    g  = -1;
    if (!reset) begin
      if (run_port >= 0 && rq[run_port]) g = run_port;
      else if (rq == 2'b11) g = m_prio;
      else if (rq == 2'b01) g = 0;
      else if (rq == 2'b10) g = 1;
    end
    ea = (g == 0) ? m0_addr : (g == 1) ? m1_addr : 32'h0;
    ew = (g == 0) ? m0_wdata : (g == 1) ? m1_wdata : 32'h0;
    eb = (g == 0) ? m0_byteen : (g == 1) ? m1_byteen : 4'h0;
    chk("m0_ack", 32'(m0_ack), 32'(g == 0));
    chk("m1_ack", 32'(m1_ack), 32'(g == 1));
    chk("mem_addr", mem_addr, ea);
    chk("mem_wdata", mem_wdata, ew);
    chk("mem_byteen", 32'(mem_byteen), 32'(eb));
    if (g >= 0) begin
      chk("owner", 32'(owner), 32'(g));
      chk("rdata", (g == 0) ? m0_rdata : m1_rdata, exp_mem[ea[5:2]]);
    end
    st_g     = g;
    st_lock  = (g == 1) ? m1_lock : m0_lock;
    st_be    = eb;
    st_addr  = ea;
    st_wdata = ew;
  end

  always @(posedge clk) begin
    int len;
    if (reset) begin
      m_prio = 0; run_port = -1; run_len = 0;
    end else if (st_g >= 0) begin
      m_prio = 1 - st_g;
      len = ((run_port == st_g) ? run_len : 0) + 1;
      if (st_lock && len < int'(LOCK_MAX)) begin
        run_port = st_g; run_len = len;
      end else begin
        run_port = -1; run_len = 0;
      end
      for (int b = 0; b < 4; b++)
        if (st_be[b]) exp_mem[st_addr[5:2]][8*b +: 8] = st_wdata[8*b +: 8];
    end else begin
      run_port = -1; run_len = 0;
    end
    st_g = -1;
  end

  int exp_seq [10] = '{0, 1, 1, 1, 1, 0, 1, 1, 1, 1};

  initial begin
    reset = 1'b1;
    m0_req = 0; m0_lock = 0; m0_addr = 0; m0_wdata = 0; m0_byteen = 0;
    m1_req = 0; m1_lock = 0; m1_addr = 0; m1_wdata = 0; m1_byteen = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_m0_ack", 32'(m0_ack), 32'h0);
    chk("rst_m1_ack", 32'(m1_ack), 32'h0);
    chk("rst_byteen", 32'(mem_byteen), 32'h0);

    // m0 write, then m1 reads the same word
    @(posedge clk); #1;
    reset = 0; m0_req = 1; m0_addr = 32'h10; m0_byteen = 4'hf; m0_wdata = 32'hdeadbeef;
    @(negedge clk);
    chk("wr_m0_ack", 32'(m0_ack), 32'h1);
    chk("wr_byteen", 32'(mem_byteen), 32'hf);
    chk("wr_addr", mem_addr, 32'h10);
    chk("wr_wdata", mem_wdata, 32'hdeadbeef);
    @(posedge clk); #1;
    m0_req = 0; m1_req = 1; m1_addr = 32'h10; m1_byteen = 4'h0;
    @(negedge clk);
    chk("rd_m1_ack", 32'(m1_ack), 32'h1);
    chk("rd_m1_rdata", m1_rdata, 32'hdeadbeef);

    // Plain alternation from reset
    @(posedge clk); #1; reset = 1;
    @(posedge clk); #1; reset = 0;
    m0_req = 1; m1_req = 1; m0_byteen = 0; m1_byteen = 0; m0_addr = 32'h4; m1_addr = 32'h8;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("alt_owner", 32'(owner), 32'(i % 2));
      chk("alt_m0_ack", 32'(m0_ack), 32'(i % 2 == 0));
      @(posedge clk); #1;
    end

    // m1 locks continuously against a constantly requesting m0
    m1_lock = 1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("lock_owner", 32'(owner), 32'(exp_seq[i]));
      @(posedge clk); #1;
    end

    // Locked m1 drops its request mid-burst
    @(negedge clk); chk("drop_a_owner", 32'(owner), 32'h0);
    @(posedge clk); #1;
    @(negedge clk); chk("drop_b_owner", 32'(owner), 32'h1);
    @(posedge clk); #1; m1_req = 0;
    @(negedge clk);
    chk("drop_m0_ack", 32'(m0_ack), 32'h1);
    chk("drop_m1_ack", 32'(m1_ack), 32'h0);
    @(posedge clk); #1;

    // Async reset in the middle of an m1 write burst
    m0_req = 0; m1_req = 1; m1_lock = 1; m1_byteen = 4'hf; m1_addr = 32'h20;
    m1_wdata = 32'ha5a50001;
    @(posedge clk); #1; m1_wdata = 32'ha5a50002;
    @(posedge clk); #1; m1_wdata = 32'h12345678;
    #2 reset = 1;
    #1;
    chk("midrst_m0_ack", 32'(m0_ack), 32'h0);
    chk("midrst_m1_ack", 32'(m1_ack), 32'h0);
    chk("midrst_byteen", 32'(mem_byteen), 32'h0);
    @(posedge clk); #1;
    chk("midrst_dm_word", dm_mem[8], 32'ha5a50002);
    @(posedge clk); #1;
    reset = 0; m0_req = 1; m1_req = 1; m0_byteen = 0; m1_byteen = 0; m1_lock = 0;
    @(negedge clk);
    chk("postrst_owner", 32'(owner), 32'h0);
    chk("postrst_m0_ack", 32'(m0_ack), 32'h1);

    // Idle
    @(posedge clk); #1; m0_req = 0; m1_req = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("idle_byteen", 32'(mem_byteen), 32'h0);
      chk("idle_acks", 32'({m1_ack, m0_ack}), 32'h0);
      chk("idle_addr", mem_addr, 32'h0);
      @(posedge clk); #1;
    end

    // Randomized traffic with occasional mid-cycle resets
    for (int i = 0; i < 3000; i++) begin
      m0_req    = ($urandom_range(0, 3) != 0);
      m1_req    = ($urandom_range(0, 3) != 0);
      m0_lock   = $urandom_range(0, 1);
      m1_lock   = $urandom_range(0, 1);
      m0_addr   = $urandom;
      m1_addr   = $urandom;
      m0_wdata  = $urandom;
      m1_wdata  = $urandom;
      m0_byteen = ($urandom_range(0, 1) != 0) ? 4'($urandom_range(0, 15)) : 4'h0;
      m1_byteen = ($urandom_range(0, 1) != 0) ? 4'($urandom_range(0, 15)) : 4'h0;
      if ($urandom_range(0, 199) == 0) begin
        #2 reset = 1;
        @(posedge clk); #1; reset = 0;
      end else begin
        @(posedge clk); #1;
      end
    end

    m0_req = 0; m1_req = 0;
    @(posedge clk); #1;
    for (int w = 0; w < 16; w++) chk("final_dm_word", dm_mem[w], exp_mem[w]);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
